matmul_seq_ctrl: RTL and testbench

- Fetch-side sequencer for the MATMUL microcode mode; sits between the F-stage PC register and the two instruction memories (normal program, matmul2 microcode).
- Decodes the custom STARTMATMUL2 / ENDMATMUL opcodes as they are fetched.
- Saves and restores the return PC, drives the instruction-memory select, and redirects the PC on entry and exit.
- Produces the pc_backup, save_pc, im_sel, toggle_fsm and state signals that the CPU top exposes.

---
 rtl/matmul_seq_ctrl.sv | 98 +++++++++
 tb/tb_matmul_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Fetch-side sequencer for MATMUL2 microcode entry/exit, PC save/restore and IMEM select.
// Optional watchdog forced-exit when MATMUL_WDOG_EN is defined (adds wdog_trip port).
module matmul_seq_ctrl #(
   parameter logic [31:0] UCODE_BASE = 32'h0000_0000,
   parameter int          WDOG_MAX   = 256,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_f,
   input  logic [31:0]      pc_f,
   input  logic             stall_f,
   input  logic             flush_d,
   output logic             pc_redir_valid,
   output logic [31:0]      pc_redir,
   output logic             im_sel,
   output logic             save_pc,
   output logic             toggle_fsm,
   output logic             state,
   output logic [31:0]      pc_backup,
   output logic [CNT_W-1:0] ucode_cnt,
`ifdef MATMUL_WDOG_EN
   output logic             wdog_trip,
`endif
   output logic             nest_err
);

   typedef enum logic [1:0] {NORMAL, ENTER, MATMUL2, EXIT} st_e;

`ifdef MATMUL_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_MAX - 1);

   st_e  st;
   logic accept, is_op, dec_start, dec_end;
   logic go_enter, go_exit, wdog_hit, nest_hit;

   assign accept    = !stall_f && !flush_d;
   assign is_op     = (instr_f[6:0] == 7'b1111010);
   assign dec_start = is_op && (instr_f[14:12] == 3'b000);
   assign dec_end   = is_op && (instr_f[14:12] == 3'b111);

   // Watchdog fires on the fetch that would take the session past WDOG_MAX
   assign wdog_hit = WDOG_EN && (st == MATMUL2) && accept && (ucode_cnt == WDOG_LIM);
   assign go_enter = (st == NORMAL) && accept && dec_start;
   assign go_exit  = (st == MATMUL2) && accept && (dec_end || wdog_hit);
   assign nest_hit = accept && (((st == MATMUL2) && dec_start) || ((st == NORMAL) && dec_end));

   assign save_pc        = go_enter;
   assign toggle_fsm     = go_enter || go_exit;
   assign pc_redir_valid = go_enter || go_exit;
   assign pc_redir       = go_enter ? UCODE_BASE : (go_exit ? pc_backup + 32'd4 : 32'd0);
   assign state          = (st == ENTER) || (st == MATMUL2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= NORMAL;
         im_sel    <= 1'b0;
         pc_backup <= '0;
         ucode_cnt <= '0;
         nest_err  <= 1'b0;
`ifdef MATMUL_WDOG_EN
         wdog_trip <= 1'b0;
`endif
      end else begin
         if (nest_hit) nest_err <= 1'b1;
         case (st)
            NORMAL: if (go_enter) begin
               pc_backup <= pc_f;
               im_sel    <= 1'b1;
               ucode_cnt <= '0;
               st        <= ENTER;
            end
            ENTER: if (!stall_f) begin
               // First microcode fetch happens here and counts toward the session
               if (!flush_d && ucode_cnt != '1) ucode_cnt <= ucode_cnt + 1'b1;
               st <= MATMUL2;
            end
            MATMUL2: begin
               if (accept && ucode_cnt != '1) ucode_cnt <= ucode_cnt + 1'b1;
               if (go_exit) begin
                  im_sel <= 1'b0;
                  st     <= EXIT;
               end
`ifdef MATMUL_WDOG_EN
               if (wdog_hit) wdog_trip <= 1'b1;
`endif
            end
            EXIT: if (!stall_f) st <= NORMAL;
            default: st <= NORMAL;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: round trip, stall, flush, nesting errors, reset, watchdog.
module tb_matmul_seq_ctrl;

   localparam logic [31:0] I_START = 32'h0000_007A;
   localparam logic [31:0] I_END   = 32'h0000_707A;
   localparam logic [31:0] I_NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_f, pc_f;
   logic        stall_f, flush_d;
   logic        pc_redir_valid, im_sel, save_pc, toggle_fsm, state, nest_err;
   logic [31:0] pc_redir, pc_backup;
   logic [15:0] ucode_cnt;
`ifdef MATMUL_WDOG_EN
   logic        wdog_trip;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   matmul_seq_ctrl #(
      .UCODE_BASE(32'h0000_0000),
`ifdef MATMUL_WDOG_EN
      .WDOG_MAX(8),
`else
      .WDOG_MAX(256),
`endif
      .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
      .stall_f(stall_f), .flush_d(flush_d),
      .pc_redir_valid(pc_redir_valid), .pc_redir(pc_redir), .im_sel(im_sel),
      .save_pc(save_pc), .toggle_fsm(toggle_fsm), .state(state),
      .pc_backup(pc_backup), .ucode_cnt(ucode_cnt),
`ifdef MATMUL_WDOG_EN
      .wdog_trip(wdog_trip),
`endif
      .nest_err(nest_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive at negedge, settle 1 time unit so combinational outputs can be checked
   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic s, input logic f);
      @(negedge clk);
      instr_f = i; pc_f = p; stall_f = s; flush_d = f;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; instr_f = I_NOP; pc_f = '0; stall_f = 1'b0; flush_d = 1'b0;
      #12;
      chk("rst_state", 32'(state), 0);
      chk("rst_im_sel", 32'(im_sel), 0);
      chk("rst_pc_backup", pc_backup, 0);
      chk("rst_cnt", 32'(ucode_cnt), 0);
      chk("rst_nest", 32'(nest_err), 0);
      chk("rst_redir_v", 32'(pc_redir_valid), 0);
      chk("rst_redir", pc_redir, 0);
      chk("rst_pulses", {30'd0, save_pc, toggle_fsm}, 0);
`ifdef MATMUL_WDOG_EN
      chk("rst_wdog", 32'(wdog_trip), 0);
`endif
      @(negedge clk); reset = 1'b1;

      // Round trip: START at 0x1C, three microcode fetches, then END
      drive(I_START, 32'h1C, 0, 0);
      chk("rt_start_pulses", {29'd0, save_pc, toggle_fsm, pc_redir_valid}, 32'h7);
      chk("rt_start_redir", pc_redir, 32'h0);
      chk("rt_start_imsel", 32'(im_sel), 0);
      tick();
      chk("rt_enter_state", 32'(state), 1);
      chk("rt_enter_imsel", 32'(im_sel), 1);
      chk("rt_pc_backup", pc_backup, 32'h1C);
      drive(I_NOP, 32'h0, 0, 0);
      chk("rt_enter_no_redir", {30'd0, toggle_fsm, pc_redir_valid}, 0);
      tick();
      drive(I_NOP, 32'h4, 0, 0); tick();
      drive(I_NOP, 32'h8, 0, 0); tick();
      drive(I_END, 32'hC, 0, 0);
      chk("rt_cnt_at_end", 32'(ucode_cnt), 3);
      chk("rt_end_pulses", {30'd0, toggle_fsm, pc_redir_valid}, 32'h3);
      chk("rt_end_save", 32'(save_pc), 0);
      chk("rt_end_redir", pc_redir, 32'h20);
      tick();
      chk("rt_exit_state", 32'(state), 0);
      chk("rt_exit_imsel", 32'(im_sel), 0);
      drive(I_NOP, 32'h20, 0, 0);
      chk("rt_exit_no_redir", 32'(pc_redir_valid), 0);
      tick();
      chk("rt_nest_clean", 32'(nest_err), 0);

      // START held under stall for two cycles
      drive(I_START, 32'h40, 1, 0);
      chk("st_stall1", {30'd0, save_pc, toggle_fsm}, 0);
      tick();
      drive(I_START, 32'h40, 1, 0);
      chk("st_stall2", {30'd0, save_pc, toggle_fsm}, 0);
      tick();
      chk("st_stall_state", 32'(state), 0);
      drive(I_START, 32'h40, 0, 0);
      chk("st_release", {30'd0, save_pc, toggle_fsm}, 32'h3);
      tick();
      chk("st_backup", pc_backup, 32'h40);
      drive(I_NOP, 32'h0, 0, 0);
      chk("st_single_pulse", {30'd0, save_pc, toggle_fsm}, 0);
      tick();
      drive(I_END, 32'h4, 0, 0);
      chk("st_end_redir", pc_redir, 32'h44);
      tick();
      drive(I_NOP, 32'h44, 0, 0); tick();

      // START colliding with flush
      drive(I_START, 32'h80, 0, 1);
      chk("fl_pulses", {29'd0, save_pc, toggle_fsm, pc_redir_valid}, 0);
      tick();
      chk("fl_state", 32'(state), 0);
      chk("fl_imsel", 32'(im_sel), 0);
      chk("fl_backup", pc_backup, 32'h40);
      chk("fl_nest", 32'(nest_err), 0);

      // END in NORMAL, then START inside MATMUL2
      drive(I_END, 32'h84, 0, 0);
      chk("il_end_pulses", {30'd0, toggle_fsm, pc_redir_valid}, 0);
      tick();
      chk("il_end_nest", 32'(nest_err), 1);
      chk("il_end_state", 32'(state), 0);
      drive(I_START, 32'h90, 0, 0); tick();
      drive(I_NOP, 32'h0, 0, 0); tick();
      drive(I_START, 32'h4, 0, 0);
      chk("il_start_pulses", {29'd0, save_pc, toggle_fsm, pc_redir_valid}, 0);
      tick();
      chk("il_start_state", 32'(state), 1);
      chk("il_start_backup", pc_backup, 32'h90);
      chk("il_start_nest", 32'(nest_err), 1);
      drive(I_NOP, 32'h8, 0, 0); tick();
      drive(I_NOP, 32'hC, 0, 0); tick();
      drive(I_NOP, 32'h10, 0, 0); tick();
      chk("rs_cnt_before", 32'(ucode_cnt), 5);

      // Asynchronous reset mid-session
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("rs_state", 32'(state), 0);
      chk("rs_imsel", 32'(im_sel), 0);
      chk("rs_backup", pc_backup, 0);
      chk("rs_cnt", 32'(ucode_cnt), 0);
      chk("rs_nest", 32'(nest_err), 0);
      @(negedge clk); reset = 1'b1;

`ifdef MATMUL_WDOG_EN
      // Watchdog with WDOG_MAX=8: seven fetches pass, the eighth forces return
      drive(I_START, 32'h100, 0, 0); tick();
      for (int k = 0; k < 7; k++) begin
         drive(I_NOP, 32'(4 * k), 0, 0);
         chk("wd_no_toggle", 32'(toggle_fsm), 0);
         tick();
      end
      drive(I_NOP, 32'h1C, 0, 0);
      chk("wd_toggle", {30'd0, toggle_fsm, pc_redir_valid}, 32'h3);
      chk("wd_redir", pc_redir, 32'h104);
      tick();
      chk("wd_state", 32'(state), 0);
      chk("wd_imsel", 32'(im_sel), 0);
      chk("wd_trip", 32'(wdog_trip), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
